// File: rtl/con_pkg.sv
// Shared definitions for the branch-condition unit: condition-code encodings
// and the bit that marks the reserved half of the code space.
package con_pkg;

  typedef logic [3:0] cc_t;

  localparam cc_t CC_BRZR   = 4'd0;
  localparam cc_t CC_BRNZ   = 4'd1;
  localparam cc_t CC_BRPL   = 4'd2;
  localparam cc_t CC_BRMI   = 4'd3;
  localparam cc_t CC_BRGE   = 4'd4;
  localparam cc_t CC_BRLE   = 4'd5;
  localparam cc_t CC_ALWAYS = 4'd6;
  localparam cc_t CC_NEVER  = 4'd7;

  // Any code with this bit set is reserved: never taken, flagged as an error.
  localparam int CC_RESERVED_BIT = 3;

endpackage

// File: rtl/con_eval.sv
// Combinational condition evaluator: maps a condition code and an operand to
// a taken flag, plus a flag for reserved codes.
module con_eval
  import con_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  cc_t              cc_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             taken_o,
  output logic             reserved_o
);

  logic sign_s;
  logic zero_s;

  assign sign_s = value_i[WIDTH-1];
  assign zero_s = (value_i == {WIDTH{1'b0}});

  // Decode the condition table; reserved codes force not-taken.
  always_comb begin
    taken_o    = 1'b0;
    reserved_o = 1'b0;
    if (cc_i[CC_RESERVED_BIT]) begin
      reserved_o = 1'b1;
      taken_o    = 1'b0;
    end else begin
      case (cc_i)
        CC_BRZR:   taken_o = zero_s;
        CC_BRNZ:   taken_o = !zero_s;
        CC_BRPL:   taken_o = !sign_s && !zero_s;
        CC_BRMI:   taken_o = sign_s;
        CC_BRGE:   taken_o = !sign_s;
        CC_BRLE:   taken_o = sign_s || zero_s;
        CC_ALWAYS: taken_o = 1'b1;
        CC_NEVER:  taken_o = 1'b0;
        default:   taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/con_unit.sv
// Branch-condition unit: optional input pipeline stage, registered
// branch-taken flag with a completion pulse, sticky reserved-code flag and
// saturating evaluated/taken counters.
module con_unit
  import con_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CONin,
  input  logic [3:0]       C2,
  input  logic [WIDTH-1:0] value,
  input  logic             clr_stats,
  output logic             result,
  output logic             result_valid,
  output logic             cond_err,
  output logic [CNT_W-1:0] eval_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Request presented to the evaluator this cycle (after the optional stage).
  logic             ev_req_s;
  cc_t              ev_c2_s;
  logic [WIDTH-1:0] ev_val_s;
  logic             taken_s;
  logic             reserved_s;

  logic             result_q, result_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] eval_q, eval_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  if (PIPE != 0) begin : g_pipe
    logic             pv_q;
    cc_t              pc2_q;
    logic [WIDTH-1:0] pval_q;

    // Input stage: capture operands only on a request so idle X never enters.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pv_q   <= 1'b0;
        pc2_q  <= 4'd0;
        pval_q <= {WIDTH{1'b0}};
      end else begin
        pv_q <= CONin;
        if (CONin) begin
          pc2_q  <= C2;
          pval_q <= value;
        end else begin
          pc2_q  <= pc2_q;
          pval_q <= pval_q;
        end
      end
    end

    assign ev_req_s = pv_q;
    assign ev_c2_s  = pc2_q;
    assign ev_val_s = pval_q;
  end else begin : g_nopipe
    // Gate operands with the request so undriven inputs stay out of the datapath.
    assign ev_req_s = CONin;
    assign ev_c2_s  = CONin ? C2 : 4'd0;
    assign ev_val_s = CONin ? value : {WIDTH{1'b0}};
  end

  con_eval #(.WIDTH(WIDTH)) u_eval (
    .cc_i      (ev_c2_s),
    .value_i   (ev_val_s),
    .taken_o   (taken_s),
    .reserved_o(reserved_s)
  );

  // Next-state: result update on completion, stats clear beats stats update.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    eval_d   = eval_q;
    taken_d  = taken_q;
    if (ev_req_s) begin
      result_d = taken_s;
      valid_d  = 1'b1;
    end else begin
      result_d = result_q;
      valid_d  = 1'b0;
    end
    if (clr_stats) begin
      err_d   = 1'b0;
      eval_d  = CNT_ZERO;
      taken_d = CNT_ZERO;
    end else if (ev_req_s) begin
      err_d   = err_q | reserved_s;
      eval_d  = (eval_q == CNT_MAX) ? eval_q : eval_q + CNT_ONE;
      if (taken_s && (taken_q != CNT_MAX)) begin
        taken_d = taken_q + CNT_ONE;
      end else begin
        taken_d = taken_q;
      end
    end else begin
      err_d   = err_q;
      eval_d  = eval_q;
      taken_d = taken_q;
    end
  end

  // Output and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      eval_q   <= CNT_ZERO;
      taken_q  <= CNT_ZERO;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      eval_q   <= eval_d;
      taken_q  <= taken_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign cond_err     = err_q;
  assign eval_count   = eval_q;
  assign taken_count  = taken_q;

endmodule

// File: tb/tb_con_unit.sv
// Scoreboard bench for con_unit: one unpipelined instance with wide counters
// and one pipelined instance with 2-bit counters share the same stimulus.
module tb_con_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         CONin;
  logic [3:0]   C2;
  logic [W-1:0] value;
  logic         clr_stats;

  logic         a_result, a_valid, a_err;
  logic [15:0]  a_eval, a_taken;
  logic         b_result, b_valid, b_err;
  logic [1:0]   b_eval, b_taken;

  con_unit #(.WIDTH(W), .PIPE(0), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .CONin(CONin), .C2(C2), .value(value),
    .clr_stats(clr_stats), .result(a_result), .result_valid(a_valid),
    .cond_err(a_err), .eval_count(a_eval), .taken_count(a_taken)
  );

  con_unit #(.WIDTH(W), .PIPE(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .CONin(CONin), .C2(C2), .value(value),
    .clr_stats(clr_stats), .result(b_result), .result_valid(b_valid),
    .cond_err(b_err), .eval_count(b_eval), .taken_count(b_taken)
  );

  int checks = 0;
  int errors = 0;

  bit qa[$];
  bit qb[$];
  bit hold_a = 1'b0;
  bit hold_b = 1'b0;

  // Reference totals since the last clear (unbounded; saturation applied on compare).
  int m_eval  = 0;
  int m_taken = 0;
  bit m_err   = 1'b0;

  function automatic bit ref_taken(int c, logic [W-1:0] v);
    bit s, z;
    s = v[W-1];
    z = (v == 0);
    case (c)
      0: return z;
      1: return !z;
      2: return !s && !z;
      3: return s;
      4: return !s;
      5: return s || z;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(int n, int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the unpipelined instance.
  always @(negedge clk) begin
    if (reset) begin
      if (a_valid) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_valid_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          hold_a = qa.pop_front();
          check("a_result", a_result, hold_a);
        end
      end else begin
        check("a_hold", a_result, hold_a);
      end
    end
  end

  // Monitor for the pipelined instance.
  always @(negedge clk) begin
    if (reset) begin
      if (b_valid) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_valid_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          hold_b = qb.pop_front();
          check("b_result", b_result, hold_b);
        end
      end else begin
        check("b_hold", b_result, hold_b);
      end
    end
  end

  task automatic issue(int c, logic [W-1:0] v);
    bit t;
    t = ref_taken(c, v);
    CONin = 1'b1;
    C2    = 4'(c);
    value = v;
    qa.push_back(t);
    qb.push_back(t);
    m_eval++;
    if (t) m_taken++;
    if (c >= 8) m_err = 1'b1;
    @(posedge clk); #1;
    CONin = 1'b0;
    C2    = 4'bxxxx;
    value = 'x;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      C2    = 4'($urandom);
      value = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_and_check(string tag);
    idle(3);
    check({tag, "_a_pending"}, qa.size(), 0);
    check({tag, "_b_pending"}, qb.size(), 0);
    check({tag, "_a_eval"},  a_eval,  sat(m_eval, 16));
    check({tag, "_a_taken"}, a_taken, sat(m_taken, 16));
    check({tag, "_a_err"},   a_err,   m_err);
    check({tag, "_b_eval"},  b_eval,  sat(m_eval, 2));
    check({tag, "_b_taken"}, b_taken, sat(m_taken, 2));
    check({tag, "_b_err"},   b_err,   m_err);
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    m_eval  = 0;
    m_taken = 0;
    m_err   = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_value();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return 32'h8000_0000 | $urandom;
      2: return $urandom;
      default: return W'($urandom_range(1, 7));
    endcase
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vals [3];
    vals[0] = 32'h0000_0000;
    vals[1] = 32'h0000_0005;
    vals[2] = 32'h8000_0000;

    reset = 1'b0; CONin = 1'b0; C2 = 4'd0; value = '0; clr_stats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_result", a_result, 0);
    check("rst_a_valid",  a_valid,  0);
    check("rst_a_eval",   a_eval,   0);
    check("rst_b_result", b_result, 0);
    check("rst_b_valid",  b_valid,  0);
    check("rst_b_taken",  b_taken,  0);
    reset = 1'b1;
    idle(2);

    // Full non-reserved table over three operands.
    foreach (vals[i]) begin
      for (int c = 0; c < 8; c++) issue(c, vals[i]);
    end
    drain_and_check("codes");

    // Back-to-back brnz on 0,1,0,1.
    clear_stats();
    issue(1, 0); issue(1, 1); issue(1, 0); issue(1, 1);
    drain_and_check("b2b");

    // Hold: result 1 then ten idle cycles of toggling operands.
    issue(6, 32'h1234);
    idle(10);
    drain_and_check("hold");

    // Reserved code, then clear coinciding with a brzr(0) completion in both instances.
    issue(8, 32'h0000_0123);
    drain_and_check("reserved");
    CONin = 1'b1; C2 = 4'd0; value = '0; clr_stats = 1'b1;
    qa.push_back(1'b1);
    qb.push_back(1'b1);
    @(posedge clk); #1;
    CONin = 1'b0; C2 = 4'bxxxx; value = 'x;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    m_eval = 0; m_taken = 0; m_err = 1'b0;
    drain_and_check("clear");
    check("clear_a_result", a_result, 1);
    check("clear_b_result", b_result, 1);

    // Saturation: five taken evaluations.
    repeat (5) issue(6, rand_value());
    drain_and_check("sat");

    // Randomized mix including reserved codes and idle gaps.
    clear_stats();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) issue(int'($urandom_range(0, 15)), rand_value());
      else idle(1);
    end
    drain_and_check("random");

    // Reset while the pipelined stage holds a request.
    issue(6, 32'h1);
    @(negedge clk); #1;
    reset = 1'b0;
    check("rstmid_a_pending", qa.size(), 0);
    qb.delete();
    hold_a = 1'b0; hold_b = 1'b0;
    m_eval = 0; m_taken = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_b_valid",  b_valid,  0);
    check("rstmid_b_result", b_result, 0);
    check("rstmid_a_result", a_result, 0);
    reset = 1'b1;
    drain_and_check("rstmid");

    issue(2, 32'h5);
    issue(5, 32'h8000_0000);
    drain_and_check("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
